// File: rtl/serial_parallel_converter.sv
// Serial-to-parallel word assembler: packs serialWidth-bit lanes into parallelWidth-bit
// words with frame attributes, a one-entry output register and sticky overflow on drop.
module serial_parallel_converter #(
    parameter int unsigned parallelWidth = 512,
    parameter int unsigned serialWidth   = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [serialWidth-1:0]                            inData,
    input  logic                                              inDataPresent,
    input  logic                                              inDataStartOfFrame,
    input  logic                                              inDataEndOfFrame,
    input  logic                                              inDataError,
    output logic [parallelWidth-1:0]                          outData,
    output logic                                              outValid,
    input  logic                                              outReady,
    output logic                                              outStartOfFrame,
    output logic                                              outEndOfFrame,
    output logic                                              outError,
    output logic [$clog2(parallelWidth/serialWidth):0]        outBytes,
    output logic                                              overflow
);

    localparam int unsigned N  = parallelWidth / serialWidth;
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

    state_t                   state_q, state_d;
    logic [parallelWidth-1:0] acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     wsof_q, wsof_d;

    logic [parallelWidth-1:0] out_data_d;
    logic                     out_valid_d, out_sof_d, out_eof_d, out_err_d, overflow_d;
    logic [CW-1:0]            out_bytes_d;

    logic [parallelWidth-1:0] word_c;
    logic [CW-1:0]            lane_c, new_cnt_c;
    logic                     new_err_c, new_sof_c;
    logic                     accept_c, partial_c, complete_c, slot_c;

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            wsof_q          <= 1'b0;
            outData         <= '0;
            outValid        <= 1'b0;
            outStartOfFrame <= 1'b0;
            outEndOfFrame   <= 1'b0;
            outError        <= 1'b0;
            outBytes        <= '0;
            overflow        <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            wsof_q          <= wsof_d;
            outData         <= out_data_d;
            outValid        <= out_valid_d;
            outStartOfFrame <= out_sof_d;
            outEndOfFrame   <= out_eof_d;
            outError        <= out_err_d;
            outBytes        <= out_bytes_d;
            overflow        <= overflow_d;
        end
    end

    // Next-state, lane assembly and output-register loading
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        wsof_d      = wsof_q;
        out_data_d  = outData;
        out_valid_d = outValid && !outReady;
        out_sof_d   = outStartOfFrame;
        out_eof_d   = outEndOfFrame;
        out_err_d   = outError;
        out_bytes_d = outBytes;
        overflow_d  = overflow;

        // A start-of-frame byte always opens a fresh word at lane 0
        lane_c = inDataStartOfFrame ? '0 : cnt_q;
        word_c = inDataStartOfFrame ? '0 : acc_q;
        for (int k = 0; k < int'(N); k++) begin
            if (lane_c == CW'(k)) begin
                word_c[k*serialWidth +: serialWidth] = inData;
            end
        end
        new_cnt_c = lane_c + CW'(1);
        new_err_c = inDataStartOfFrame ? inDataError : (err_q || inDataError);
        new_sof_c = inDataStartOfFrame ? 1'b1 : wsof_q;

        accept_c   = inDataPresent && (inDataStartOfFrame || state_q == FILL);
        partial_c  = inDataPresent && inDataStartOfFrame && state_q == FILL && cnt_q != '0;
        complete_c = accept_c && (new_cnt_c == CW'(N) || inDataEndOfFrame);
        slot_c     = !outValid || outReady;

        // Interrupted frame: flush the pending partial word as a truncated, errored EOF word
        if (partial_c) begin
            if (slot_c) begin
                out_data_d  = acc_q;
                out_bytes_d = cnt_q;
                out_sof_d   = wsof_q;
                out_eof_d   = 1'b1;
                out_err_d   = 1'b1;
                out_valid_d = 1'b1;
                slot_c      = 1'b0;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (accept_c) begin
            if (complete_c) begin
                acc_d  = '0;
                cnt_d  = '0;
                err_d  = new_err_c;
                wsof_d = 1'b0;
                if (slot_c) begin
                    out_data_d  = word_c;
                    out_bytes_d = new_cnt_c;
                    out_sof_d   = new_sof_c;
                    out_eof_d   = inDataEndOfFrame;
                    out_err_d   = new_err_c;
                    out_valid_d = 1'b1;
                    state_d     = inDataEndOfFrame ? IDLE : FILL;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = DROP;
                end
            end else begin
                acc_d   = word_c;
                cnt_d   = new_cnt_c;
                err_d   = new_err_c;
                wsof_d  = new_sof_c;
                state_d = FILL;
            end
        end else if (inDataPresent && state_q == DROP && inDataEndOfFrame) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_serial_parallel_converter.sv
// Scoreboard bench for serial_parallel_converter (8-bit lanes into 32-bit words).
module tb_serial_parallel_converter;

    localparam int unsigned PW = 32;
    localparam int unsigned SW = 8;

    typedef struct {
        logic [PW-1:0] data;
        logic          sof;
        logic          eof;
        logic          err;
        logic [2:0]    bytes;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] inData = '0;
    logic          inDataPresent = 1'b0;
    logic          inDataStartOfFrame = 1'b0;
    logic          inDataEndOfFrame = 1'b0;
    logic          inDataError = 1'b0;
    logic [PW-1:0] outData;
    logic          outValid;
    logic          outReady = 1'b1;
    logic          outStartOfFrame;
    logic          outEndOfFrame;
    logic          outError;
    logic [2:0]    outBytes;
    logic          overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    serial_parallel_converter #(.parallelWidth(PW), .serialWidth(SW)) dut (
        .clk(clk), .rst(rst),
        .inData(inData), .inDataPresent(inDataPresent),
        .inDataStartOfFrame(inDataStartOfFrame), .inDataEndOfFrame(inDataEndOfFrame),
        .inDataError(inDataError),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .outStartOfFrame(outStartOfFrame), .outEndOfFrame(outEndOfFrame),
        .outError(outError), .outBytes(outBytes), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [PW-1:0] d, input logic s, input logic e,
                               input logic r, input logic [2:0] b);
        exp_t x;
        x.data = d; x.sof = s; x.eof = e; x.err = r; x.bytes = b;
        q.push_back(x);
    endtask

    task automatic send(input logic [SW-1:0] b, input logic s, input logic e, input logic r);
        inData = b; inDataPresent = 1'b1;
        inDataStartOfFrame = s; inDataEndOfFrame = e; inDataError = r;
        @(posedge clk); #1;
        inDataPresent = 1'b0; inDataStartOfFrame = 1'b0;
        inDataEndOfFrame = 1'b0; inDataError = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 64'(outValid), 64'd0);
        chk({tag, "_data"}, 64'(outData), 64'd0);
        chk({tag, "_attr"}, 64'({outStartOfFrame, outEndOfFrame, outError, outBytes}), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    // Monitor: every transfer is compared against the oldest expected word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (outValid && outReady && !rst) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual data=%0h bytes=%0d expected none",
                             outData, outBytes);
                end else begin
                    e = q.pop_front();
                    if (outData !== e.data || outStartOfFrame !== e.sof || outEndOfFrame !== e.eof ||
                        outError !== e.err || outBytes !== e.bytes) begin
                        errors++;
                        $display("FAIL word actual data=%0h sof=%0b eof=%0b err=%0b bytes=%0d expected data=%0h sof=%0b eof=%0b err=%0b bytes=%0d",
                                 outData, outStartOfFrame, outEndOfFrame, outError, outBytes,
                                 e.data, e.sof, e.eof, e.err, e.bytes);
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("reset");

        // Basic 4-byte frame with latency check
        expect_word(32'h44332211, 1, 1, 0, 3'd4);
        send(8'h11, 1, 0, 0); send(8'h22, 0, 0, 0); send(8'h33, 0, 0, 0); send(8'h44, 0, 1, 0);
        @(negedge clk);
        chk("latency_valid", 64'(outValid), 64'd1);
        idle(2);

        // 6-byte frame: full word then 2-byte tail
        expect_word(32'h04030201, 1, 0, 0, 3'd4);
        expect_word(32'h00000605, 0, 1, 0, 3'd2);
        for (int i = 1; i <= 6; i++) send(8'(i), i == 1, i == 6, 0);
        idle(2);

        // Single byte with SOF+EOF+error
        expect_word(32'h000000AA, 1, 1, 1, 3'd1);
        send(8'hAA, 1, 1, 1);
        idle(2);

        // SOF interrupts a 2-byte partial word
        expect_word(32'h00000201, 1, 1, 1, 3'd2);
        expect_word(32'h06050403, 1, 1, 0, 3'd4);
        send(8'h01, 1, 0, 0); send(8'h02, 0, 0, 0);
        send(8'h03, 1, 0, 0); send(8'h04, 0, 0, 0); send(8'h05, 0, 0, 0); send(8'h06, 0, 1, 0);
        idle(2);

        // Stray byte in IDLE is discarded; gaps inside a frame are allowed
        expect_word(32'h00B3B2B1, 1, 1, 0, 3'd3);
        send(8'hA1, 0, 0, 0);
        send(8'hB1, 1, 0, 0); idle(1); send(8'hB2, 0, 0, 0); idle(2); send(8'hB3, 0, 1, 0);
        idle(2);

        // Frame error flag persists across words of the frame
        expect_word(32'hC4C3C2C1, 1, 0, 1, 3'd4);
        expect_word(32'h000000C5, 0, 1, 1, 3'd1);
        send(8'hC1, 1, 0, 0); send(8'hC2, 0, 0, 1); send(8'hC3, 0, 0, 0);
        send(8'hC4, 0, 0, 0); send(8'hC5, 0, 1, 0);
        idle(2);

        // Backpressure: first word held, second frame dropped with overflow
        outReady = 1'b0;
        expect_word(32'h14131211, 1, 1, 0, 3'd4);
        for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), i == 1, i == 4, 0);
        for (int i = 1; i <= 4; i++) begin
            send(8'(8'h20 + i), i == 1, i == 4, 0);
            @(negedge clk);
            chk("held_valid", 64'(outValid), 64'd1);
            chk("held_data", 64'(outData), 64'h14131211);
        end
        chk("overflow_set", 64'(overflow), 64'd1);
        idle(2);
        chk("held_data_late", 64'(outData), 64'h14131211);
        outReady = 1'b1;
        idle(2);
        chk("popped_valid", 64'(outValid), 64'd0);
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Reset with a held word and a partial frame, then bytes without SOF
        outReady = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(8'h40 + i), i == 1, i == 4, 0);
        send(8'h51, 1, 0, 0); send(8'h52, 0, 0, 0); send(8'h53, 0, 0, 0);
        chk("pre_reset_valid", 64'(outValid), 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        outReady = 1'b1;
        send(8'h34, 0, 0, 0); send(8'h35, 0, 1, 0);
        idle(2);
        @(negedge clk);
        chk_reset_values("post_reset");

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parallel_converter.md
SERIAL_PARALLEL_CONVERTER -- requirements
Module: serial_parallel_converter

Interface
REQ-001 Parameter parallelWidth, default 512: output word width in bits.
REQ-002 Parameter serialWidth, default 8: input lane width; parallelWidth SHALL be an integer multiple of serialWidth; N = parallelWidth/serialWidth >= 2.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 inData  in  serialWidth  serial data lane.
REQ-006 inDataPresent  in  1  inData valid this cycle; no backpressure to serial side.
REQ-007 inDataStartOfFrame / inDataEndOfFrame / inDataError  in  1 each  qualified by inDataPresent.
REQ-008 outData  out  parallelWidth  assembled word, lane k = bits [k*serialWidth +: serialWidth].
REQ-009 outValid  out  1; outReady  in  1; transfer occurs when both high.
REQ-010 outStartOfFrame / outEndOfFrame / outError  out  1 each  word attributes.
REQ-011 outBytes  out  clog2(N)+1  number of valid lanes in outData (1..N).
REQ-012 overflow  out  1  sticky; a word was dropped.

Function
REQ-013 States IDLE, FILL, DROP; reset state IDLE.
REQ-014 Present bytes without SOF in IDLE SHALL be discarded.
REQ-015 Present+SOF in any state: byte written to lane 0, lane count = 1, frame-error flag = inDataError, word-SOF flag set, go to FILL.
REQ-016 Present in FILL: byte written to next lane (lane count increments); frame-error flag ORs inDataError.
REQ-017 Word complete when lane count reaches N or byte has EOF; SOF+EOF on same byte gives one word, outBytes = 1.
REQ-018 Complete word moves to output register on the cycle after the completing byte (latency 1) if output register empty or popped that same cycle.
REQ-019 outError SHALL equal frame-error flag at completion; outEndOfFrame set only on EOF word; outStartOfFrame only on first word of frame.
REQ-020 Unused lanes of outData SHALL be zero.
REQ-021 After non-EOF completion stay in FILL with lane count 0; after EOF go to IDLE.
REQ-022 SOF arriving in FILL with lane count > 0: pending partial word emitted with outEndOfFrame = 1, outError = 1; new byte starts next word at lane 0 in the same cycle.
REQ-023 Output register held stable while outValid && !outReady.
REQ-024 Completion while output register full and not popping: word dropped, overflow = 1, state DROP.
REQ-025 DROP discards bytes until EOF (then IDLE) or SOF (handled per REQ-015); already-emitted words of that frame are not recalled.
REQ-026 Present low: no state change; gaps inside a frame are allowed.

Reset
REQ-027 rst high at a clock edge: state IDLE, lane count 0, flags 0, output register empty.
REQ-028 Reset values: outValid 0, outData 0, outStartOfFrame 0, outEndOfFrame 0, outError 0, outBytes 0, overflow 0.
REQ-029 rst asserted mid-frame or with outValid high: partial and held words discarded, no output transfer on reset cycles.

Verification
REQ-030 serialWidth 8, parallelWidth 32, outReady=1; bytes 11,22,33,44 (SOF first, EOF last) -> one word 0x44332211, sof=1 eof=1 bytes=4, outValid one cycle after byte 44.
REQ-031 Same config, 6-byte frame 01..06 -> word 0x04030201 sof=1 eof=0 bytes=4, then 0x00000605 sof=0 eof=1 bytes=2.
REQ-032 Single byte AA with SOF+EOF+error -> word 0x000000AA, bytes=1, sof=eof=error=1.
REQ-033 outReady=0, two back-to-back 4-byte frames -> first word held stable, second dropped, overflow=1, no further outValid changes until outReady.
REQ-034 SOF after 2 bytes 01,02, new frame 03..06 with EOF -> 0x00000201 eof=1 error=1 bytes=2, then 0x06050403 sof=1 eof=1 error=0.
REQ-035 rst pulsed after 3 bytes of a frame, then bytes without SOF -> nothing emitted; all outputs at reset values.
